pad_mux_ctrl: RTL and testbench

//  Sits between the SoC peripherals and the padring. Each of NPADS bidirectional

---
 rtl/pad_mux_pkg.sv | 12 +
 rtl/pad_mux_sync.sv | 28 ++
 rtl/pad_mux_ctrl.sv | 109 ++++++++++
 tb/tb_pad_mux_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pad_mux_pkg.sv
// rtl/pad_mux_pkg.sv - shared types and constants for the pad ownership controller
package pad_mux_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BREAK  = 2'd1,
    COMMIT = 2'd2
  } pad_mux_state_e;

endpackage

// File: rtl/pad_mux_sync.sv
// rtl/pad_mux_sync.sv - multi-stage flop synchroniser for asynchronous pad inputs
module pad_mux_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] ff_q;

  // Shift the raw pad value through STAGES flops; only the last stage is used.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= '0;
    end else begin
      ff_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        ff_q[i] <= ff_q[i-1];
      end
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/pad_mux_ctrl.sv
// rtl/pad_mux_ctrl.sv - break-before-make pad ownership sequencer and pad mux
module pad_mux_ctrl
  import pad_mux_pkg::*;
#(
  parameter int               NPADS        = 32,
  parameter int               BREAK_CYCLES = 4,
  parameter int               SYNC_STAGES  = 2,
  parameter logic [NPADS-1:0] RESET_SEL    = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_valid_i,
  input  logic [NPADS-1:0] cfg_sel_i,
  output logic             cfg_ready_o,
  output logic [NPADS-1:0] sel_o,
  output logic             busy_o,
  input  logic [NPADS-1:0] gpio_out_i,
  input  logic [NPADS-1:0] gpio_oe_i,
  output logic [NPADS-1:0] gpio_in_o,
  input  logic [NPADS-1:0] alt_out_i,
  input  logic [NPADS-1:0] alt_oe_i,
  output logic [NPADS-1:0] alt_in_o,
  output logic [NPADS-1:0] pad_out_o,
  output logic [NPADS-1:0] pad_oe_o,
  input  logic [NPADS-1:0] pad_in_i
);

  pad_mux_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NPADS-1:0] sel_q, sel_d;
  logic [NPADS-1:0] nsel_q, nsel_d;
  logic [NPADS-1:0] pend_q, pend_d;
  logic [NPADS-1:0] pad_in_sync;
  logic [NPADS-1:0] chg;

  assign chg = cfg_sel_i ^ sel_q;

  // Sequencer registers; reset drops any in-flight switch and restores RESET_SEL.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= RESET_SEL;
      nsel_q  <= RESET_SEL;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      nsel_q  <= nsel_d;
      pend_q  <= pend_d;
    end
  end

  // Next state: a mask that changes nothing is absorbed in IDLE without a break.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    nsel_d  = nsel_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid_i && (chg != '0)) begin
          pend_d  = chg;
          nsel_d  = cfg_sel_i;
          cnt_d   = CNT_W'(BREAK_CYCLES - 1);
          state_d = BREAK;
        end
      end
      BREAK: begin
        if (cnt_q == '0) begin
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      COMMIT: begin
        sel_d   = nsel_q;
        pend_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  pad_mux_sync #(
    .WIDTH  (NPADS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pad_in_i),
    .q_o    (pad_in_sync)
  );

  // Pad mux: pending pads are forced quiet; others follow the committed owner.
  always_comb begin
    pad_out_o = ~pend_q & ((sel_q & alt_out_i) | (~sel_q & gpio_out_i));
    pad_oe_o  = ~pend_q & ((sel_q & alt_oe_i)  | (~sel_q & gpio_oe_i));
    gpio_in_o = pad_in_sync & ~sel_q & ~pend_q;
    alt_in_o  = pad_in_sync &  sel_q & ~pend_q;
  end

  assign sel_o       = sel_q;
  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// tb/tb_pad_mux_ctrl.sv - directed vector bench for pad_mux_ctrl
module tb_pad_mux_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic [31:0] cfg_sel;
  logic        cfg_ready;
  logic [31:0] sel;
  logic        busy;
  logic [31:0] gpio_out, gpio_oe, gpio_in;
  logic [31:0] alt_out, alt_oe, alt_in;
  logic [31:0] pad_out, pad_oe, pad_in;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] g_out;
    logic [31:0] g_oe;
    logic [31:0] a_out;
    logic [31:0] a_oe;
    logic [31:0] exp_out;
    logic [31:0] exp_oe;
  } vec_t;

  vec_t vec_sel0 [3];
  vec_t vec_sel3 [3];

  pad_mux_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_valid_i (cfg_valid),
    .cfg_sel_i   (cfg_sel),
    .cfg_ready_o (cfg_ready),
    .sel_o       (sel),
    .busy_o      (busy),
    .gpio_out_i  (gpio_out),
    .gpio_oe_i   (gpio_oe),
    .gpio_in_o   (gpio_in),
    .alt_out_i   (alt_out),
    .alt_oe_i    (alt_oe),
    .alt_in_o    (alt_in),
    .pad_out_o   (pad_out),
    .pad_oe_o    (pad_oe),
    .pad_in_i    (pad_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_drive();
    gpio_out = 32'hA5A5A5A5;
    gpio_oe  = 32'hFFFFFFFF;
    alt_out  = 32'h00000000;
    alt_oe   = 32'hFFFFFFFF;
  endtask

  task automatic run_table(input string tag, input vec_t v);
    gpio_out = v.g_out;
    gpio_oe  = v.g_oe;
    alt_out  = v.a_out;
    alt_oe   = v.a_oe;
    #1;
    check({tag, "_pad_out"}, pad_out, v.exp_out);
    check({tag, "_pad_oe"},  pad_oe,  v.exp_oe);
  endtask

  initial begin
    vec_sel0[0] = '{32'hA5A5A5A5, 32'hFFFFFFFF, 32'h12345678, 32'h00000000, 32'hA5A5A5A5, 32'hFFFFFFFF};
    vec_sel0[1] = '{32'h0F0F0F0F, 32'h00FF00FF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h00FF00FF};
    vec_sel0[2] = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    vec_sel3[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFD};
    vec_sel3[1] = '{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003, 32'h00000003};
    vec_sel3[2] = '{32'h5555AAAA, 32'hF0F0F0F0, 32'hFFFFFFFC, 32'hFFFFFFFE, 32'h5555AAA8, 32'hF0F0F0F2};

    // Reset state
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_sel   = '0;
    pad_in    = '0;
    set_default_drive();
    #1;
    check("rst_pad_oe", pad_oe, 32'hFFFFFFFF);
    check("rst_pad_out", pad_out, 32'hA5A5A5A5);
    check("rst_ready", {31'b0, cfg_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_sel", sel, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) run_table($sformatf("tbl0_%0d", i), vec_sel0[i]);
    set_default_drive();

    // Break-before-make on pads 0..1
    cfg_sel   = 32'h00000003;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("brk_pad_out", pad_out, 32'hA5A5A5A4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("brk%0d_pad_oe", k), pad_oe, 32'hFFFFFFFC);
      check($sformatf("brk%0d_busy", k), {31'b0, busy}, 32'd1);
      check($sformatf("brk%0d_ready", k), {31'b0, cfg_ready}, 32'd0);
      check($sformatf("brk%0d_sel", k), sel, 32'h0);
      tick();
    end
    check("commit_pad_oe", pad_oe, 32'hFFFFFFFC);
    check("commit_busy", {31'b0, busy}, 32'd1);
    tick();
    check("done_sel", sel, 32'h00000003);
    check("done_busy", {31'b0, busy}, 32'd0);
    check("done_ready", {31'b0, cfg_ready}, 32'd1);
    check("done_pad_oe", pad_oe, 32'hFFFFFFFF);
    check("done_pad_out", pad_out, 32'hA5A5A5A4);

    for (int i = 0; i < 3; i++) run_table($sformatf("tbl3_%0d", i), vec_sel3[i]);
    set_default_drive();

    // Mask equal to current ownership is a no-op
    cfg_sel   = 32'h00000003;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("same_busy", {31'b0, busy}, 32'd0);
    check("same_ready", {31'b0, cfg_ready}, 32'd1);
    tick();
    check("same_busy2", {31'b0, busy}, 32'd0);
    check("same_sel", sel, 32'h00000003);

    // Synchronised input routing: pad 0 alt-owned, pad 5 gpio-owned
    pad_in = 32'h00000021;
    tick();
    check("sync1_alt_in", alt_in, 32'h0);
    tick();
    check("sync2_alt_in", alt_in, 32'h00000001);
    check("sync2_gpio_in", gpio_in, 32'h00000020);

    // Held valid across BREAK: second mask taken in first IDLE cycle
    cfg_sel   = 32'h00000002;
    cfg_valid = 1'b1;
    tick();
    cfg_sel   = 32'h0000000F;
    check("hold_brk_busy", {31'b0, busy}, 32'd1);
    check("hold_brk_pad_oe", pad_oe, 32'hFFFFFFFE);
    check("hold_brk_alt_in", alt_in, 32'h0);
    check("hold_brk_gpio_in", gpio_in, 32'h00000020);
    for (int k = 0; k < 4; k++) tick();
    check("hold_commit_ready", {31'b0, cfg_ready}, 32'd0);
    check("hold_commit_sel", sel, 32'h00000003);
    tick();
    check("hold_idle_sel", sel, 32'h00000002);
    check("hold_idle_ready", {31'b0, cfg_ready}, 32'd1);
    check("hold_idle_gpio_in", gpio_in, 32'h00000021);
    check("hold_idle_pad_oe", pad_oe, 32'hFFFFFFFF);
    tick();
    cfg_valid = 1'b0;
    check("second_busy", {31'b0, busy}, 32'd1);
    check("second_pad_oe", pad_oe, 32'hFFFFFFF2);
    check("second_gpio_in", gpio_in, 32'h00000020);
    check("second_alt_in", alt_in, 32'h0);
    for (int k = 0; k < 5; k++) tick();
    check("second_sel", sel, 32'h0000000F);
    check("second_done_busy", {31'b0, busy}, 32'd0);
    check("second_done_gpio_in", gpio_in, 32'h00000020);
    check("second_done_alt_in", alt_in, 32'h00000001);

    // Asynchronous reset in the middle of BREAK
    cfg_sel   = 32'h00000000;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
    check("mid_pad_oe", pad_oe, 32'hFFFFFFF0);
    rst_n = 1'b0;
    #1;
    check("arst_sel", sel, 32'h0);
    check("arst_pad_oe", pad_oe, 32'hFFFFFFFF);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_ready", {31'b0, cfg_ready}, 32'd1);
    check("arst_gpio_in", gpio_in, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    check("post_rst_sel", sel, 32'h0);
    check("post_rst_gpio_in", gpio_in, 32'h00000021);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
